// File: rtl/edp_mqseq.sv
// edp_mqseq -- iterative multiply/divide sequencer for the EBOX data path.
//
// The sequencer computes one bit per clock. An AR-style accumulator (acc, W+1
// bits) and an MQ-style shift register (mq, W bits) are stepped together.
// The double-width result is returned as hi/lo words.
//
// Operations (op):
//   00  unsigned multiply          hi:lo = a * b
//   01  signed (two's-compl) MUL   hi:lo = a * b
//   10  unsigned restoring divide  lo = a / b, hi = a % b
//   11  illegal                    err = 1, hi = lo = 0
//
// Optional feature macro EDP_MQSEQ_DIV_EN:
//   - Defined: op=10 runs the restoring divide. A zero divisor gives
//     err=1, hi=a, lo=all ones.
//   - Undefined: the divide datapath is not built, and op=10 is treated as
//     illegal.
//
// Ports:
//   clk    in   data-path clock, rising edge
//   rst_n  in   synchronous active-low reset
//   start  in   request, accepted only in IDLE with abort low
//   op     in   [1:0] operation select
//   a      in   [W-1:0] multiplicand / dividend
//   b      in   [W-1:0] multiplier / divisor
//   abort  in   cancel a running operation (no done, outputs untouched)
//   busy   out  high while an operation is in RUN or DONE
//   done   out  one-cycle completion pulse; hi/lo/err valid from here on
//   err    out  divide by zero or illegal op
//   hi     out  [W-1:0] product high word / remainder
//   lo     out  [W-1:0] product low word / quotient
module edp_mqseq #(
  parameter int W = 36,
  localparam int CNT_W = $clog2(W + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         abort,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [W:0]       acc_reg;    // AR: partial product / partial remainder
  logic [W-1:0]     mq_reg;     // MQ: multiplier bits / quotient bits
  logic [W-1:0]     opnd_reg;   // multiplicand (MUL) or divisor (DIV)
  logic             sgn_reg;
  logic [W-1:0]     hi_reg, lo_reg;
  logic             err_reg;

  logic             accept;
  logic             op_illegal;
  logic             op_bad;
  logic             last_step;
  logic             is_div_op;

  logic [W:0]       mul_addend;
  logic [W:0]       mul_sum;
  logic [W:0]       acc_step;
  logic [W-1:0]     mq_step;

`ifdef EDP_MQSEQ_DIV_EN
  logic             div_reg;
  logic             div_zero;
  logic [W:0]       div_shift;
  logic [W+1:0]     div_trial;  // one extra bit so the sign of R-b is visible

  assign is_div_op  = (op == 2'b10);
  assign op_illegal = (op == 2'b11);
  assign div_zero   = is_div_op && (b == '0);
  assign op_bad     = op_illegal || div_zero;
`else
  assign is_div_op  = 1'b0;
  assign op_illegal = op[1];
  assign op_bad     = op_illegal;
`endif

  assign accept    = (state_reg == S_IDLE) && start && !abort;
  assign last_step = (cnt_reg == CNT_W'(1));

  // ---------------------------------------------------------------------
  // One iteration step of the datapath.
  // ---------------------------------------------------------------------
  always_comb begin
    // The multiplicand is sign-extended only for the signed multiply.
    mul_addend = {sgn_reg & opnd_reg[W-1], opnd_reg};
    if (!mq_reg[0]) begin
      mul_sum = acc_reg;
    end else if (sgn_reg && last_step) begin
      // In two's complement, the multiplier MSB carries negative weight.
      mul_sum = acc_reg - mul_addend;
    end else begin
      mul_sum = acc_reg + mul_addend;
    end
    // For the unsigned multiply, the carry (bit W) shifts down and a zero
    // enters at the top. For the signed multiply, the sign is replicated.
    acc_step = {sgn_reg & mul_sum[W], mul_sum[W:1]};
    mq_step  = {mul_sum[0], mq_reg[W-1:1]};
`ifdef EDP_MQSEQ_DIV_EN
    div_shift = {acc_reg[W-1:0], mq_reg[W-1]};
    div_trial = {1'b0, div_shift} - {2'b00, opnd_reg};
    if (div_reg) begin
      acc_step = div_trial[W+1] ? div_shift : div_trial[W:0];
      mq_step  = {mq_reg[W-2:0], ~div_trial[W+1]};
    end
`endif
  end

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (accept) begin
          state_next = op_bad ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_next = S_IDLE;
        end else if (last_step) begin
          state_next = S_DONE;
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------
  always_comb begin
    busy = (state_reg != S_IDLE);
    done = (state_reg == S_DONE);
    err  = err_reg;
    hi   = hi_reg;
    lo   = lo_reg;
  end

  // ---------------------------------------------------------------------
  // Working registers and result registers.
  // The results are written on the edge that enters DONE, so they are
  // already valid while done is high. They are held until the next
  // completion.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_reg  <= '0;
      acc_reg  <= '0;
      mq_reg   <= '0;
      opnd_reg <= '0;
      sgn_reg  <= 1'b0;
      hi_reg   <= '0;
      lo_reg   <= '0;
      err_reg  <= 1'b0;
`ifdef EDP_MQSEQ_DIV_EN
      div_reg  <= 1'b0;
`endif
    end else if (accept) begin
      acc_reg  <= '0;
      sgn_reg  <= (op == 2'b01);
      // Divide keeps the dividend in MQ and the divisor in the operand reg.
      opnd_reg <= is_div_op ? b : a;
      mq_reg   <= is_div_op ? a : b;
`ifdef EDP_MQSEQ_DIV_EN
      div_reg  <= is_div_op;
`endif
      if (op_bad) begin
        cnt_reg <= '0;
        err_reg <= 1'b1;
        hi_reg  <= '0;
        lo_reg  <= '0;
`ifdef EDP_MQSEQ_DIV_EN
        if (div_zero) begin
          hi_reg <= a;
          lo_reg <= '1;
        end
`endif
      end else begin
        cnt_reg <= CNT_W'(W);
      end
    end else if (state_reg == S_RUN) begin
      if (abort) begin
        cnt_reg <= '0;
      end else begin
        acc_reg <= acc_step;
        mq_reg  <= mq_step;
        cnt_reg <= cnt_reg - CNT_W'(1);
        if (last_step) begin
          hi_reg  <= acc_step[W-1:0];
          lo_reg  <= mq_step;
          err_reg <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_edp_mqseq.sv
// Directed testbench for edp_mqseq. It uses a W=8 instance for most vectors
// and a W=36 instance for the full-width multiply.
module tb_edp_mqseq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        start8 = 1'b0, abort8 = 1'b0;
  logic [1:0]  op8 = 2'b00;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy8, done8, err8;
  logic [7:0]  hi8, lo8;

  logic        start36 = 1'b0, abort36 = 1'b0;
  logic [1:0]  op36 = 2'b00;
  logic [35:0] a36 = '0, b36 = '0;
  logic        busy36, done36, err36;
  logic [35:0] hi36, lo36;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  edp_mqseq #(.W(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .op(op8), .a(a8), .b(b8),
    .abort(abort8), .busy(busy8), .done(done8), .err(err8), .hi(hi8), .lo(lo8)
  );

  edp_mqseq #(.W(36)) u_dut36 (
    .clk(clk), .rst_n(rst_n), .start(start36), .op(op36), .a(a36), .b(b36),
    .abort(abort36), .busy(busy36), .done(done36), .err(err36), .hi(hi36), .lo(lo36)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Runs one W=8 operation. Latency is counted in negedges after the
  // accepting edge: 0 means done is visible in the cycle right after
  // acceptance. If poke is set, start is re-pulsed with other operands
  // while the operation is busy; it must be ignored.
  task automatic run8(input string tag, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] exp_hi, input logic [7:0] exp_lo, input logic exp_err,
                      input int exp_lat, input bit poke);
    int lat = -1;
    int n_done = 0;
    logic [7:0] got_hi = '0, got_lo = '0;
    logic got_err = 1'b0;
    @(negedge clk);
    start8 = 1'b1; op8 = op; a8 = a; b8 = b;
    @(posedge clk);
    #1;
    start8 = 1'b0; a8 = 8'h5A; b8 = 8'hA5; op8 = 2'b00;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (i == 0) check_val({tag, " busy"}, 64'(busy8), 64'd1);
      if (done8) begin
        n_done++;
        if (lat < 0) begin
          lat = i; got_hi = hi8; got_lo = lo8; got_err = err8;
        end
      end
      if (poke) begin
        start8 = (i == 2 || i == 3);
        a8 = 8'h11; b8 = 8'h22;
      end
      @(posedge clk);
      #1;
    end
    start8 = 1'b0;
    $display("%s: op=%0d a=0x%02h b=0x%02h -> hi=0x%02h lo=0x%02h err=%0d lat=%0d",
             tag, op, a, b, got_hi, got_lo, got_err, lat);
    check_val({tag, " lat"}, 64'(lat), 64'(exp_lat));
    check_val({tag, " ndone"}, 64'(n_done), 64'd1);
    check_val({tag, " hi"}, 64'(got_hi), 64'(exp_hi));
    check_val({tag, " lo"}, 64'(got_lo), 64'(exp_lo));
    check_val({tag, " err"}, 64'(got_err), 64'(exp_err));
    @(negedge clk);
    check_val({tag, " hi_hold"}, 64'(hi8), 64'(exp_hi));
    check_val({tag, " lo_hold"}, 64'(lo8), 64'(exp_lo));
  endtask

  initial begin
    int lat;
    int n_done;
    // reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst busy", 64'(busy8), 64'd0);
    check_val("rst done", 64'(done8), 64'd0);
    check_val("rst err", 64'(err8), 64'd0);
    check_val("rst hi", 64'(hi8), 64'd0);
    check_val("rst lo", 64'(lo8), 64'd0);
    rst_n = 1'b1;

    run8("umul ff*ff", 2'b00, 8'hFF, 8'hFF, 8'hFE, 8'h01, 1'b0, 8, 1'b1);
    run8("umul 12*34", 2'b00, 8'h12, 8'h34, 8'h03, 8'hA8, 1'b0, 8, 1'b0);
    run8("smul fd*05", 2'b01, 8'hFD, 8'h05, 8'hFF, 8'hF1, 1'b0, 8, 1'b0);
    run8("smul 80*80", 2'b01, 8'h80, 8'h80, 8'h40, 8'h00, 1'b0, 8, 1'b0);
    run8("smul 7f*81", 2'b01, 8'h7F, 8'h81, 8'hC0, 8'hFF, 1'b0, 8, 1'b0);
`ifdef EDP_MQSEQ_DIV_EN
    run8("div 100/7", 2'b10, 8'd100, 8'd7, 8'h02, 8'h0E, 1'b0, 8, 1'b0);
    run8("div ff/10", 2'b10, 8'hFF, 8'h10, 8'h0F, 8'h0F, 1'b0, 8, 1'b0);
    run8("div 55/0", 2'b10, 8'h55, 8'h00, 8'h55, 8'hFF, 1'b1, 0, 1'b0);
`else
    run8("div off 100/7", 2'b10, 8'd100, 8'd7, 8'h00, 8'h00, 1'b1, 0, 1'b0);
    run8("div off 55/0", 2'b10, 8'h55, 8'h00, 8'h00, 8'h00, 1'b1, 0, 1'b0);
`endif
    run8("illegal op", 2'b11, 8'h12, 8'h34, 8'h00, 8'h00, 1'b1, 0, 1'b0);

    // W=36 full-width unsigned multiply
    @(negedge clk);
    start36 = 1'b1; op36 = 2'b00; a36 = 36'o777777777777; b36 = 36'd2;
    @(posedge clk);
    #1;
    start36 = 1'b0; a36 = '0; b36 = '0;
    lat = -1;
    for (int i = 0; i < 45 && lat < 0; i++) begin
      @(negedge clk);
      if (done36) lat = i;
      else begin
        @(posedge clk);
        #1;
      end
    end
    $display("umul36: hi=0x%0h lo=0x%0h err=%0d lat=%0d", hi36, lo36, err36, lat);
    check_val("umul36 lat", 64'(lat), 64'd36);
    check_val("umul36 hi", 64'(hi36), 64'd1);
    check_val("umul36 lo", 64'(lo36), 64'(36'o777777777776));
    check_val("umul36 err", 64'(err36), 64'd0);

    // Establish a known prior result, then abort at RUN step 3.
    run8("umul prior", 2'b00, 8'hFF, 8'hFF, 8'hFE, 8'h01, 1'b0, 8, 1'b0);
    @(negedge clk);
    start8 = 1'b1; op8 = 2'b00; a8 = 8'h12; b8 = 8'h34;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    n_done = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (done8) n_done++;
      abort8 = (i == 2);
      @(posedge clk);
      #1;
    end
    abort8 = 1'b0;
    @(negedge clk);
    $display("abort: hi=0x%02h lo=0x%02h busy=%0d dones=%0d", hi8, lo8, busy8, n_done);
    check_val("abort ndone", 64'(n_done), 64'd0);
    check_val("abort busy", 64'(busy8), 64'd0);
    check_val("abort hi", 64'(hi8), 64'hFE);
    check_val("abort lo", 64'(lo8), 64'h01);

    // start and abort together in IDLE: the request is dropped.
    start8 = 1'b1; abort8 = 1'b1;
    @(posedge clk);
    #1;
    start8 = 1'b0; abort8 = 1'b0;
    @(negedge clk);
    $display("start+abort: busy=%0d", busy8);
    check_val("start+abort busy", 64'(busy8), 64'd0);

    // Reset mid-RUN with a start pulse while busy.
    start8 = 1'b1; op8 = 2'b01; a8 = 8'h33; b8 = 8'h44;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    n_done = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (done8) n_done++;
      start8 = (i == 1);
      if (i == 3) begin
        check_val("prerst hi", 64'(hi8), 64'hFE);
        check_val("prerst lo", 64'(lo8), 64'h01);
      end
      rst_n = !(i == 3);
      @(posedge clk);
      #1;
    end
    rst_n = 1'b1;
    start8 = 1'b0;
    @(negedge clk);
    $display("midrst: hi=0x%02h lo=0x%02h err=%0d busy=%0d dones=%0d", hi8, lo8, err8, busy8, n_done);
    check_val("midrst ndone", 64'(n_done), 64'd0);
    check_val("midrst hi", 64'(hi8), 64'd0);
    check_val("midrst lo", 64'(lo8), 64'd0);
    check_val("midrst busy", 64'(busy8), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
